mem_bus_arbiter: RTL and testbench

// - Shares the single-port system memory between the 65C02 core and one DMA/block-transfer requester.
// - Sits between the CPU (AB/DO/WE/DI/RDY) and the memory (addr/dIn/we/dOut).
// - Stalls the CPU through RDY while the DMA owns the bus.
// - Bounds DMA bursts so the CPU always gets at least one cycle every MAX_BURST+1 cycles.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port synchronous-read memory between the 65C02 core and a DMA requester.
//
// The CPU is stalled through cpu_rdy while the DMA owns the bus. DMA bursts are
// capped at MAX_BURST consecutive owned cycles, after which one CPU cycle is forced.
//
// Parameters:
//   ADDR_W     address width (CPU, DMA and memory)
//   DATA_W     data width
//   MAX_BURST  max consecutive DMA-owned cycles before a forced CPU cycle (1..255)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_ab/cpu_do/cpu_we       CPU bus request (held by the CPU while cpu_rdy=0)
//   cpu_di, cpu_rdy            CPU read data, CPU ready
//   dma_req/dma_ab/dma_do/dma_we  DMA access request
//   dma_gnt, dma_di, dma_rvalid   DMA owns bus, DMA read data and its valid strobe
//   mem_addr/mem_din/mem_we    memory request
//   mem_dout                   memory read data, one cycle after mem_addr
//
// Optional feature (macro ARB_STATS_EN):
//   stall_cnt     saturating count of cycles with cpu_rdy=0
//   dma_xfer_cnt  saturating count of cycles with dma_req && dma_gnt
module mem_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_ab,
    input  logic [DATA_W-1:0] cpu_do,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_di,
    output logic              cpu_rdy,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_ab,
    input  logic [DATA_W-1:0] dma_do,
    input  logic              dma_we,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_di,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       dma_xfer_cnt
`endif
);

    typedef enum logic [1:0] {S_CPU, S_DMA, S_YIELD} state_t;

    localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

    state_t            state, state_nx;
    logic [7:0]        burst_cnt, burst_nx;
    logic              owner_dma;
    logic              rd_owner_q, rd_we_q, rd_req_q;
    logic [DATA_W-1:0] cpu_di_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CPU;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
        end
    end

    always_comb begin
        state_nx = state;
        burst_nx = burst_cnt;
        case (state)
            S_CPU: begin
                state_nx = dma_req ? S_DMA : S_CPU;
                burst_nx = '0;
            end
            S_DMA: begin
                // a dropped request wins over reaching the burst limit
                if (!dma_req)
                    state_nx = S_CPU;
                else if (burst_cnt == LAST)
                    state_nx = S_YIELD;
                else
                    burst_nx = burst_cnt + 8'd1;
            end
            S_YIELD: begin
                state_nx = dma_req ? S_DMA : S_CPU;
                burst_nx = '0;
            end
            default: state_nx = S_CPU;
        endcase
    end

    assign owner_dma = (state == S_DMA);
    assign cpu_rdy   = !owner_dma;
    assign dma_gnt   = owner_dma;

    always_comb begin
        mem_addr = owner_dma ? dma_ab : cpu_ab;
        mem_din  = owner_dma ? dma_do : cpu_do;
        mem_we   = owner_dma ? (dma_we & dma_req) : cpu_we;
    end

    // Tag each access with its owner so the synchronous read data is steered
    // to whoever issued it one cycle earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q  <= 1'b0;
            rd_we_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            cpu_di_hold <= '0;
        end else begin
            rd_owner_q <= owner_dma;
            rd_we_q    <= mem_we;
            rd_req_q   <= dma_req;
            if (!rd_owner_q)
                cpu_di_hold <= mem_dout;
        end
    end

    // CPU sees its last read value while DMA data is on mem_dout
    assign cpu_di     = rd_owner_q ? cpu_di_hold : mem_dout;
    assign dma_di     = mem_dout;
    assign dma_rvalid = rd_owner_q && !rd_we_q && rd_req_q;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            dma_xfer_cnt <= '0;
        end else begin
            if (!cpu_rdy && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (dma_req && dma_gnt && dma_xfer_cnt != 16'hFFFF)
                dma_xfer_cnt <= dma_xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter with a synchronous-read memory model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_ab = '0;
    logic [7:0]  cpu_do = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        dma_req = 1'b0;
    logic [15:0] dma_ab = '0;
    logic [7:0]  dma_do = '0;
    logic        dma_we = 1'b0;
    logic        dma_gnt;
    logic [7:0]  dma_di;
    logic        dma_rvalid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_dout = '0;
`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] dma_xfer_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic [7:0] mem [0:65535];
    logic [7:0] sh [0:65535];
    logic [7:0] cpu_q [$];
    logic [7:0] dma_q [$];

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_ab(dma_ab), .dma_do(dma_do), .dma_we(dma_we),
        .dma_gnt(dma_gnt), .dma_di(dma_di), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
`ifdef ARB_STATS_EN
        , .stall_cnt(stall_cnt), .dma_xfer_cnt(dma_xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        nxt;
        nxt;
        reset = 1'b0;
        @(negedge clk);
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", cpu_rdy); end
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0", dma_gnt); end
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", dma_rvalid); end
        total++; if (cpu_di !== 8'h00) begin bad++; $display("FAIL reset_cpu_di got=%h want=00", cpu_di); end
`ifdef ARB_STATS_EN
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_stall got=%h want=0", stall_cnt); end
        total++; if (dma_xfer_cnt !== 16'h0) begin bad++; $display("FAIL reset_xfer got=%h want=0", dma_xfer_cnt); end
`endif
        nxt;
    endtask

    task automatic test_cpu_only;
        logic [15:0] ad [4];
        logic [7:0]  e;
        cpu_ab = 16'h0200; cpu_do = 8'hA5; cpu_we = 1'b1; sh[16'h0200] = 8'hA5;
        @(negedge clk);
        total++; if (mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_din !== 8'hA5) begin bad++;
            $display("FAIL cpu_wr got=%b/%h/%h want=1/0200/a5", mem_we, mem_addr, mem_din); end
        nxt;
        cpu_we = 1'b0;
        cpu_q.push_back(sh[16'h0200]);
        @(negedge clk);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL cpu_rd_we got=%b want=0", mem_we); end
        nxt;
        cpu_ab = 16'h0000;
        @(negedge clk);
        e = cpu_q.pop_front();
        total++; if (cpu_di !== e) begin bad++; $display("FAIL cpu_rd got=%h want=%h", cpu_di, e); end
        nxt;
        for (int i = 0; i < 4; i++) begin
            ad[i] = 16'h1000 + 16'(i * 256) + 16'($urandom_range(0, 255));
            cpu_ab = ad[i]; cpu_do = 8'($urandom); cpu_we = 1'b1; sh[ad[i]] = cpu_do;
            nxt;
        end
        cpu_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) cpu_ab = ad[i];
            @(negedge clk);
            if (i > 0) begin
                e = cpu_q.pop_front();
                total++; if (cpu_di !== e) begin bad++; $display("FAIL cpu_rand_rd%0d got=%h want=%h", i - 1, cpu_di, e); end
            end
            if (i < 4) cpu_q.push_back(sh[ad[i]]);
            nxt;
        end
    endtask

    task automatic test_single_dma;
        logic [7:0] e;
        cpu_ab = 16'h0200; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_ab = 16'h0300; dma_do = 8'h3C;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1 || mem_addr !== 16'h0200) begin bad++;
            $display("FAIL sdma_req_cycle got=%b/%b/%h want=0/1/0200", dma_gnt, cpu_rdy, mem_addr); end
        cpu_q.push_back(sh[16'h0200]);
        nxt;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1 || cpu_rdy !== 1'b0) begin bad++;
            $display("FAIL sdma_gnt got=%b/%b want=1/0", dma_gnt, cpu_rdy); end
        total++; if (mem_we !== 1'b1 || mem_addr !== 16'h0300 || mem_din !== 8'h3C) begin bad++;
            $display("FAIL sdma_wr got=%b/%h/%h want=1/0300/3c", mem_we, mem_addr, mem_din); end
        e = cpu_q.pop_front();
        total++; if (cpu_di !== e) begin bad++; $display("FAIL sdma_cpu_di got=%h want=%h", cpu_di, e); end
        sh[16'h0300] = 8'h3C;
        nxt;
        dma_req = 1'b0;
        @(negedge clk);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL sdma_idle_we got=%b want=0", mem_we); end
        nxt;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1) begin bad++;
            $display("FAIL sdma_release got=%b/%b want=0/1", dma_gnt, cpu_rdy); end
        nxt;
        cpu_ab = 16'h0300;
        cpu_q.push_back(sh[16'h0300]);
        nxt;
        @(negedge clk);
        e = cpu_q.pop_front();
        total++; if (cpu_di !== e) begin bad++; $display("FAIL sdma_readback got=%h want=%h", cpu_di, e); end
        nxt;
    endtask

    task automatic test_burst;
        logic exp_g;
        logic [7:0] e;
        cpu_ab = 16'h0200; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_ab = 16'h0500; dma_do = 8'h77;
        for (int k = 0; k < 22; k++) begin
            if (k == 20) dma_req = 1'b0;
            @(negedge clk);
            exp_g = (k >= 1 && k <= 20 && k != 9 && k != 18);
            total++; if (dma_gnt !== exp_g) begin bad++; $display("FAIL burst_gnt[%0d] got=%b want=%b", k, dma_gnt, exp_g); end
            total++; if (cpu_rdy !== !exp_g) begin bad++; $display("FAIL burst_rdy[%0d] got=%b want=%b", k, cpu_rdy, !exp_g); end
            if (k == 10 || k == 19) begin
                e = cpu_q.pop_front();
                total++; if (cpu_di !== e) begin bad++; $display("FAIL burst_yield_rd[%0d] got=%h want=%h", k, cpu_di, e); end
            end
            if (k == 9 || k == 18) cpu_q.push_back(sh[16'h0200]);
            nxt;
        end
        sh[16'h0500] = 8'h77;
    endtask

    task automatic test_dma_read(input logic [15:0] a);
        logic [7:0] e;
        cpu_ab = 16'h0200; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_ab = a;
        cpu_q.push_back(sh[16'h0200]);
        @(negedge clk);
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL drd_req_gnt got=%b want=0", dma_gnt); end
        nxt;
        @(negedge clk);
        total++; if (dma_gnt !== 1'b1 || mem_addr !== a || mem_we !== 1'b0) begin bad++;
            $display("FAIL drd_access got=%b/%h/%b want=1/%h/0", dma_gnt, mem_addr, mem_we, a); end
        e = cpu_q.pop_front();
        total++; if (cpu_di !== e) begin bad++; $display("FAIL drd_cpu_di0 got=%h want=%h", cpu_di, e); end
        dma_q.push_back(sh[a]);
        nxt;
        dma_req = 1'b0;
        @(negedge clk);
        e = dma_q.pop_front();
        total++; if (dma_rvalid !== 1'b1 || dma_di !== e) begin bad++;
            $display("FAIL drd_return got=%b/%h want=1/%h", dma_rvalid, dma_di, e); end
        total++; if (cpu_di !== sh[16'h0200]) begin bad++; $display("FAIL drd_cpu_hold1 got=%h want=%h", cpu_di, sh[16'h0200]); end
        nxt;
        @(negedge clk);
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL drd_rvalid_off got=%b want=0", dma_rvalid); end
        total++; if (cpu_di !== sh[16'h0200]) begin bad++; $display("FAIL drd_cpu_hold2 got=%h want=%h", cpu_di, sh[16'h0200]); end
        nxt;
    endtask

    task automatic test_drop_at_limit;
        cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_ab = 16'h0600; dma_do = 8'h42;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) dma_req = 1'b0;
            if (k == 10) dma_req = 1'b1;
            if (k == 11) dma_req = 1'b0;
            @(negedge clk);
            if (k == 8) begin
                total++; if (dma_gnt !== 1'b1 || mem_we !== 1'b0) begin bad++;
                    $display("FAIL limit_drop got=%b/%b want=1/0", dma_gnt, mem_we); end
            end
            if (k == 9 || k == 10) begin
                total++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1) begin bad++;
                    $display("FAIL limit_cpu[%0d] got=%b/%b want=0/1", k, dma_gnt, cpu_rdy); end
            end
            if (k == 11) begin
                total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL limit_regrant got=%b want=1", dma_gnt); end
            end
            nxt;
        end
        nxt;
        sh[16'h0600] = 8'h42;
    endtask

    task automatic test_reset_mid_burst;
        dma_req = 1'b1; dma_we = 1'b0; dma_ab = 16'h0200;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) reset = 1'b1;
            if (k == 5) begin reset = 1'b0; dma_req = 1'b0; end
            @(negedge clk);
            if (k == 2) begin
                total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL rmid_rvalid_pre got=%b want=1", dma_rvalid); end
            end
            if (k == 4) begin
                total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt_pre got=%b want=1", dma_gnt); end
            end
            if (k == 5) begin
                total++; if (dma_gnt !== 1'b0 || cpu_rdy !== 1'b1 || dma_rvalid !== 1'b0) begin bad++;
                    $display("FAIL rmid_after got=%b/%b/%b want=0/1/0", dma_gnt, cpu_rdy, dma_rvalid); end
`ifdef ARB_STATS_EN
                total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL rmid_stall got=%h want=0", stall_cnt); end
`endif
            end
            nxt;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            sh[i] = 8'h00;
        end
        test_reset;
        test_cpu_only;
        test_single_dma;
        test_burst;
        test_dma_read(16'h0200);
        test_dma_read(16'h0300);
        test_dma_read(16'h0500);
        test_drop_at_limit;
        test_reset_mid_burst;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
